// File: rtl/axi4_burst_master.sv
// AXI4 INCR burst master: turns one local read/write command into at most two
// AXI4 bursts (split at a 4KB page boundary) and streams data to/from the requester.
module axi4_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_W-1:0]     cmd_addr_i,
    input  logic [7:0]            cmd_len_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR_o,
    output logic [7:0]            M_AXI_AWLEN_o,
    output logic [2:0]            M_AXI_AWSIZE_o,
    output logic [1:0]            M_AXI_AWBURST_o,
    output logic                  M_AXI_AWVALID_o,
    input  logic                  M_AXI_AWREADY_i,
    output logic [DATA_W-1:0]     M_AXI_WDATA_o,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB_o,
    output logic                  M_AXI_WLAST_o,
    output logic                  M_AXI_WVALID_o,
    input  logic                  M_AXI_WREADY_i,
    input  logic [1:0]            M_AXI_BRESP_i,
    input  logic                  M_AXI_BVALID_i,
    output logic                  M_AXI_BREADY_o,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR_o,
    output logic [7:0]            M_AXI_ARLEN_o,
    output logic [2:0]            M_AXI_ARSIZE_o,
    output logic [1:0]            M_AXI_ARBURST_o,
    output logic                  M_AXI_ARVALID_o,
    input  logic                  M_AXI_ARREADY_i,
    input  logic [DATA_W-1:0]     M_AXI_RDATA_i,
    input  logic [1:0]            M_AXI_RRESP_i,
    input  logic                  M_AXI_RLAST_i,
    input  logic                  M_AXI_RVALID_i,
    output logic                  M_AXI_RREADY_o
);

    localparam int BYTES  = DATA_W / 8;
    localparam int SIZE   = $clog2(BYTES);
    localparam int PAGE_W = ADDR_W - 12;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BYTES - 1));

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_axAddr;
    logic [7:0]        r_axLen;
    logic [ADDR_W-1:0] r_pendAddr;
    logic [7:0]        r_pendLen;
    logic              r_pendValid;
    logic [7:0]        r_beatCnt;
    logic              r_err;
    logic              r_done;

    logic [ADDR_W-1:0] w_alignedAddr;
    logic [12:0]       w_pageOffset;
    logic [12:0]       w_room;
    logic [8:0]        w_beats;
    logic              w_fits;
    logic [7:0]        w_firstLen;
    logic [7:0]        w_secondLen;
    logic [ADDR_W-1:0] w_nextPage;
    logic              w_cmdFire;
    logic              w_awFire;
    logic              w_wFire;
    logic              w_bFire;
    logic              w_arFire;
    logic              w_rFire;
    logic              w_lastBeat;
    logic              w_burstEnd;

    // Split arithmetic: room is the number of whole beats left before the 4KB page ends.
    assign w_alignedAddr = cmd_addr_i & ALIGN_MASK;
    assign w_pageOffset  = {1'b0, w_alignedAddr[11:0]};
    assign w_room        = (13'd4096 - w_pageOffset) >> SIZE;
    assign w_beats       = {1'b0, cmd_len_i} + 9'd1;
    assign w_fits        = ({4'b0000, w_beats} <= w_room);
    assign w_firstLen    = 8'(w_room - 13'd1);
    assign w_secondLen   = 8'(w_beats - w_room[8:0] - 9'd1);
    assign w_nextPage    = {w_alignedAddr[ADDR_W-1:12] + PAGE_W'(1), 12'h000};

    assign w_cmdFire  = cmd_valid_i && (r_state == S_IDLE);
    assign w_awFire   = (r_state == S_AW) && M_AXI_AWREADY_i;
    assign w_wFire    = (r_state == S_W) && wvalid_i && M_AXI_WREADY_i;
    assign w_bFire    = (r_state == S_B) && M_AXI_BVALID_i;
    assign w_arFire   = (r_state == S_AR) && M_AXI_ARREADY_i;
    assign w_rFire    = (r_state == S_R) && M_AXI_RVALID_i && rready_i;
    assign w_lastBeat = (r_beatCnt == 8'd0);
    assign w_burstEnd = w_bFire || (w_rFire && w_lastBeat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_cmdFire) r_state <= cmd_write_i ? S_AW : S_AR;
                S_AW:   if (w_awFire) r_state <= S_W;
                S_W:    if (w_wFire && w_lastBeat) r_state <= S_B;
                S_B:    if (w_bFire) r_state <= r_pendValid ? S_AW : S_IDLE;
                S_AR:   if (w_arFire) r_state <= S_R;
                S_R:    if (w_rFire && w_lastBeat) r_state <= r_pendValid ? S_AR : S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The second burst's address/length are computed at accept time and swapped in later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_axAddr    <= '0;
            r_axLen     <= '0;
            r_pendAddr  <= '0;
            r_pendLen   <= '0;
            r_pendValid <= 1'b0;
        end else if (w_cmdFire) begin
            r_axAddr    <= w_alignedAddr;
            r_axLen     <= w_fits ? cmd_len_i : w_firstLen;
            r_pendAddr  <= w_nextPage;
            r_pendLen   <= w_secondLen;
            r_pendValid <= !w_fits;
        end else if (w_burstEnd && r_pendValid) begin
            r_axAddr    <= r_pendAddr;
            r_axLen     <= r_pendLen;
            r_pendValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beatCnt <= '0;
        end else if (w_awFire || w_arFire) begin
            r_beatCnt <= r_axLen;
        end else if ((w_wFire || w_rFire) && !w_lastBeat) begin
            r_beatCnt <= r_beatCnt - 8'd1;
        end
    end

    // Error is sticky across both bursts of a command and only cleared by a new accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_cmdFire) begin
            r_err <= 1'b0;
        end else if (w_bFire && (M_AXI_BRESP_i != 2'b00)) begin
            r_err <= 1'b1;
        end else if (w_rFire && ((M_AXI_RRESP_i != 2'b00) || (M_AXI_RLAST_i != w_lastBeat))) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_burstEnd && !r_pendValid;
        end
    end

    assign cmd_ready_o     = (r_state == S_IDLE);
    assign done_o          = r_done;
    assign err_o           = r_err;

    assign M_AXI_AWADDR_o  = r_axAddr;
    assign M_AXI_AWLEN_o   = r_axLen;
    assign M_AXI_AWSIZE_o  = 3'(SIZE);
    assign M_AXI_AWBURST_o = 2'b01;
    assign M_AXI_AWVALID_o = (r_state == S_AW);

    assign M_AXI_WDATA_o   = wdata_i;
    assign M_AXI_WSTRB_o   = '1;
    assign M_AXI_WLAST_o   = (r_state == S_W) && w_lastBeat;
    assign M_AXI_WVALID_o  = (r_state == S_W) && wvalid_i;
    assign wready_o        = (r_state == S_W) && M_AXI_WREADY_i;
    assign M_AXI_BREADY_o  = (r_state == S_B);

    assign M_AXI_ARADDR_o  = r_axAddr;
    assign M_AXI_ARLEN_o   = r_axLen;
    assign M_AXI_ARSIZE_o  = 3'(SIZE);
    assign M_AXI_ARBURST_o = 2'b01;
    assign M_AXI_ARVALID_o = (r_state == S_AR);

    assign rdata_o         = (r_state == S_R) ? M_AXI_RDATA_i : '0;
    assign rvalid_o        = (r_state == S_R) && M_AXI_RVALID_i;
    assign M_AXI_RREADY_o  = (r_state == S_R) && rready_i;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: drives commands and plays the AXI slave
// cycle by cycle from tasks, comparing outputs against hand-computed values.
module tb_axi4_burst_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [7:0]        cmd_len_i;
    logic [DATA_W-1:0] wdata_i;
    logic              wvalid_i;
    logic              wready_o;
    logic [DATA_W-1:0] rdata_o;
    logic              rvalid_o;
    logic              rready_i;
    logic              done_o;
    logic              err_o;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    int nChecks   = 0;
    int nFailures = 0;

    axi4_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .done_o(done_o), .err_o(err_o),
        .M_AXI_AWADDR_o(awaddr), .M_AXI_AWLEN_o(awlen), .M_AXI_AWSIZE_o(awsize),
        .M_AXI_AWBURST_o(awburst), .M_AXI_AWVALID_o(awvalid), .M_AXI_AWREADY_i(awready),
        .M_AXI_WDATA_o(wdata), .M_AXI_WSTRB_o(wstrb), .M_AXI_WLAST_o(wlast),
        .M_AXI_WVALID_o(wvalid), .M_AXI_WREADY_i(wready),
        .M_AXI_BRESP_i(bresp), .M_AXI_BVALID_i(bvalid), .M_AXI_BREADY_o(bready),
        .M_AXI_ARADDR_o(araddr), .M_AXI_ARLEN_o(arlen), .M_AXI_ARSIZE_o(arsize),
        .M_AXI_ARBURST_o(arburst), .M_AXI_ARVALID_o(arvalid), .M_AXI_ARREADY_i(arready),
        .M_AXI_RDATA_i(rdata), .M_AXI_RRESP_i(rresp), .M_AXI_RLAST_i(rlast),
        .M_AXI_RVALID_i(rvalid), .M_AXI_RREADY_o(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFailures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Every task starts and ends just after a falling edge; inputs change there.
    task automatic applyStimulus(input logic isWrite, input logic [31:0] addr, input logic [7:0] len);
        cmd_valid_i = 1'b1;
        cmd_write_i = isWrite;
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        #1;
        checkOutput("cmd_ready_idle", cmd_ready_o, 1);
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic awPhase(input logic [31:0] addr, input logic [7:0] len, input int delay);
        for (int i = 0; i <= delay; i++) begin
            awready = (i == delay);
            #1;
            checkOutput("awvalid", awvalid, 1);
            checkOutput("awaddr", awaddr, addr);
            checkOutput("awlen", awlen, len);
            checkOutput("aw_cmd_ready", cmd_ready_o, 0);
            checkOutput("aw_no_early_w", wready_o, 0);
            if (i == 0) checkOutput("aw_no_done", done_o, 0);
            @(negedge clk);
        end
        awready = 1'b0;
    endtask

    task automatic arPhase(input logic [31:0] addr, input logic [7:0] len, input int delay);
        for (int i = 0; i <= delay; i++) begin
            arready = (i == delay);
            #1;
            checkOutput("arvalid", arvalid, 1);
            checkOutput("araddr", araddr, addr);
            checkOutput("arlen", arlen, len);
            checkOutput("ar_cmd_ready", cmd_ready_o, 0);
            if (i == 0) checkOutput("ar_no_done", done_o, 0);
            @(negedge clk);
        end
        arready = 1'b0;
    endtask

    task automatic wPhase(input int len, input logic toggle);
        int beat = 0;
        for (int cyc = 0; cyc < 1000 && beat <= len; cyc++) begin
            wready   = toggle ? (cyc % 2 == 0) : 1'b1;
            wvalid_i = 1'b1;
            wdata_i  = 32'hA000 + beat;
            #1;
            checkOutput("wvalid", wvalid, 1);
            checkOutput("wready_o", wready_o, wready);
            checkOutput("w_cmd_ready", cmd_ready_o, 0);
            if (wready) begin
                checkOutput("wdata", wdata, 32'hA000 + beat);
                checkOutput("wlast", wlast, beat == len);
                beat++;
            end
            @(negedge clk);
        end
        wready   = 1'b0;
        wvalid_i = 1'b0;
        checkOutput("w_beat_count", beat, len + 1);
    endtask

    task automatic bPhase(input logic [1:0] resp);
        bvalid = 1'b1;
        bresp  = resp;
        #1;
        checkOutput("bready", bready, 1);
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = 2'b00;
    endtask

    task automatic rPhase(input int len, input int base, input int errBeat, input int badLast, input logic toggle);
        int beat = 0;
        for (int cyc = 0; cyc < 1000 && beat <= len; cyc++) begin
            rready_i = toggle ? (cyc % 2 == 0) : 1'b1;
            rvalid   = 1'b1;
            rdata    = 32'hB000 + base + beat;
            rlast    = (beat == len) ^ (beat == badLast);
            rresp    = (beat == errBeat) ? 2'b10 : 2'b00;
            #1;
            checkOutput("rvalid_o", rvalid_o, 1);
            checkOutput("rdata_o", rdata_o, 32'hB000 + base + beat);
            checkOutput("rready", rready, rready_i);
            if (rready_i) beat++;
            @(negedge clk);
        end
        rvalid   = 1'b0;
        rlast    = 1'b0;
        rresp    = 2'b00;
        rready_i = 1'b0;
        checkOutput("r_beat_count", beat, len + 1);
    endtask

    task automatic checkDone(input logic expErr);
        #1;
        checkOutput("done_pulse", done_o, 1);
        checkOutput("done_err", err_o, expErr);
        checkOutput("done_cmd_ready", cmd_ready_o, 1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = '0; cmd_len_i = '0;
        wdata_i = '0; wvalid_i = 0; rready_i = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0; arready = 0;
        rdata = '0; rresp = 0; rlast = 0; rvalid = 0;
        #3;
        checkOutput("rst_cmd_ready", cmd_ready_o, 1);
        checkOutput("rst_awvalid", awvalid, 0);
        checkOutput("rst_arvalid", arvalid, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_awaddr", awaddr, 0);
        checkOutput("rst_awlen", awlen, 0);
        checkOutput("awsize", awsize, 2);
        checkOutput("arsize", arsize, 2);
        checkOutput("awburst", awburst, 1);
        checkOutput("arburst", arburst, 1);
        checkOutput("wstrb", wstrb, 4'hF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] write 0x1000 len 3, delayed AWREADY, toggling WREADY");
        applyStimulus(1'b1, 32'h1000, 8'd3);
        awPhase(32'h1000, 8'd3, 2);
        wPhase(3, 1'b1);
        bPhase(2'b00);
        checkDone(1'b0);

        $display("[TB] read 0xFF8 len 3 split across 4KB page");
        applyStimulus(1'b0, 32'h0FF8, 8'd3);
        arPhase(32'h0FF8, 8'd1, 0);
        rPhase(1, 0, -1, -1, 1'b0);
        arPhase(32'h1000, 8'd1, 1);
        rPhase(1, 2, -1, -1, 1'b0);
        checkDone(1'b0);

        $display("[TB] read 0x0 len 7 with RRESP error on third beat");
        applyStimulus(1'b0, 32'h0, 8'd7);
        arPhase(32'h0, 8'd7, 0);
        rPhase(7, 0, 2, -1, 1'b1);
        checkDone(1'b1);
        applyStimulus(1'b0, 32'h40, 8'd0);
        arPhase(32'h40, 8'd0, 0);
        rPhase(0, 16, -1, -1, 1'b0);
        checkDone(1'b0);

        $display("[TB] RLAST protocol errors and BRESP error");
        applyStimulus(1'b0, 32'h83, 8'd1);
        arPhase(32'h80, 8'd1, 0);
        rPhase(1, 32, -1, 0, 1'b0);
        checkDone(1'b1);
        applyStimulus(1'b0, 32'hC0, 8'd1);
        arPhase(32'hC0, 8'd1, 0);
        rPhase(1, 48, -1, 1, 1'b0);
        checkDone(1'b1);
        applyStimulus(1'b1, 32'h80, 8'd0);
        awPhase(32'h80, 8'd0, 0);
        wPhase(0, 1'b0);
        bPhase(2'b10);
        checkDone(1'b1);

        $display("[TB] write 0x0 len 255, no split");
        applyStimulus(1'b1, 32'h0, 8'd255);
        awPhase(32'h0, 8'd255, 0);
        wPhase(255, 1'b0);
        bPhase(2'b00);
        checkDone(1'b0);

        $display("[TB] reset during second write beat");
        applyStimulus(1'b1, 32'h3000, 8'd3);
        awPhase(32'h3000, 8'd3, 0);
        wready = 1'b1; wvalid_i = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_wvalid", wvalid, 0);
        checkOutput("arst_wready_o", wready_o, 0);
        checkOutput("arst_cmd_ready", cmd_ready_o, 1);
        checkOutput("arst_bready", bready, 0);
        checkOutput("arst_awaddr", awaddr, 0);
        checkOutput("arst_awlen", awlen, 0);
        @(negedge clk);
        rst_n = 1'b1; wready = 1'b0; wvalid_i = 1'b0;
        applyStimulus(1'b0, 32'h2000, 8'd0);
        arPhase(32'h2000, 8'd0, 0);
        rPhase(0, 80, -1, -1, 1'b0);
        checkDone(1'b0);

        $display("[TB] command held during active write");
        applyStimulus(1'b1, 32'h100, 8'd1);
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h500; cmd_len_i = 8'd0;
        awPhase(32'h100, 8'd1, 0);
        wPhase(1, 1'b0);
        bPhase(2'b00);
        checkDone(1'b0);
        cmd_valid_i = 1'b0;
        arPhase(32'h500, 8'd0, 0);
        rPhase(0, 96, -1, -1, 1'b0);
        checkDone(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFailures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation timed out");
    end

endmodule
